// File: rtl/lut_layer_sequencer.sv
// lut_layer_sequencer: runtime-programmable layer of 6-input LUT neurons, one neuron per cycle.
// Rev 1.0
`default_nettype none

module lut_layer_sequencer #(
  parameter int IN_WIDTH    = 128,
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = 7,
  parameter int NID_W       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   cfg_ready,
  input  logic                   cfg_tt_we,
  input  logic                   cfg_map_we,
  input  logic [NID_W-1:0]       cfg_neuron,
  input  logic [63:0]            cfg_tt_data,
  input  logic [6*IDX_W-1:0]     cfg_map_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_WIDTH-1:0]    in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_NEURONS-1:0] out_data,
  output logic                   busy
);

  localparam int PAD_W = 2 ** IDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  logic [NID_W-1:0]       cnt;
  logic [IN_WIDTH-1:0]    in_reg;
  logic [63:0]            tt_mem  [NUM_NEURONS];
  logic [6*IDX_W-1:0]     map_mem [NUM_NEURONS];

  logic [PAD_W-1:0]       in_pad;
  logic [63:0]            sel_tt;
  logic [6*IDX_W-1:0]     sel_map;
  logic [5:0]             lut_addr;
  logic                   lut_bit;
  logic                   last_neuron;

  assign cfg_ready   = (state == IDLE);
  assign in_ready    = (state == IDLE) && !(cfg_tt_we || cfg_map_we);
  assign busy        = (state != IDLE);
  assign last_neuron = (cnt == NID_W'(NUM_NEURONS - 1));

  // Zero-extended copy of the input so fan-in indices past IN_WIDTH read as 0.
  always_comb begin
    in_pad                 = '0;
    in_pad[IN_WIDTH-1:0]   = in_reg;
  end

  // Neuron select is a decoded mux so any NID_W wider than needed stays safe.
  always_comb begin
    sel_tt  = '0;
    sel_map = '0;
    for (int n = 0; n < NUM_NEURONS; n++) begin
      if (cnt == NID_W'(n)) begin
        sel_tt  = tt_mem[n];
        sel_map = map_mem[n];
      end
    end
  end

  always_comb begin
    lut_addr = '0;
    for (int k = 0; k < 6; k++) begin
      lut_addr[k] = in_pad[sel_map[k*IDX_W +: IDX_W]];
    end
    lut_bit = sel_tt[lut_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        tt_mem[n]  <= '0;
        map_mem[n] <= '0;
      end
    end else if (cfg_ready) begin
      for (int n = 0; n < NUM_NEURONS; n++) begin
        if (cfg_neuron == NID_W'(n)) begin
          if (cfg_tt_we)  tt_mem[n]  <= cfg_tt_data;
          if (cfg_map_we) map_mem[n] <= cfg_map_data;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      in_reg    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_reg   <= in_data;
            cnt      <= '0;
            out_data <= '0;
            state    <= EVAL;
          end
        end
        EVAL: begin
          for (int n = 0; n < NUM_NEURONS; n++) begin
            if (cnt == NID_W'(n)) out_data[n] <= lut_bit;
          end
          if (last_neuron) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + NID_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lut_layer_sequencer.sv
// Directed self-checking bench for lut_layer_sequencer (IN_WIDTH=100, NID_W=5).
`default_nettype none

module tb_lut_layer_sequencer;

  localparam int IN_WIDTH    = 100;
  localparam int NUM_NEURONS = 16;
  localparam int IDX_W       = 7;
  localparam int NID_W       = 5;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   cfg_ready;
  logic                   cfg_tt_we = 1'b0;
  logic                   cfg_map_we = 1'b0;
  logic [NID_W-1:0]       cfg_neuron = '0;
  logic [63:0]            cfg_tt_data = '0;
  logic [6*IDX_W-1:0]     cfg_map_data = '0;
  logic                   in_valid = 1'b0;
  logic                   in_ready;
  logic [IN_WIDTH-1:0]    in_data = '0;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [NUM_NEURONS-1:0] out_data;
  logic                   busy;

  int errors = 0;
  int checks = 0;

  lut_layer_sequencer #(
    .IN_WIDTH(IN_WIDTH), .NUM_NEURONS(NUM_NEURONS), .IDX_W(IDX_W), .NID_W(NID_W)
  ) dut (
    .clk(clk), .rst(rst), .cfg_ready(cfg_ready), .cfg_tt_we(cfg_tt_we),
    .cfg_map_we(cfg_map_we), .cfg_neuron(cfg_neuron), .cfg_tt_data(cfg_tt_data),
    .cfg_map_data(cfg_map_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6*IDX_W-1:0] rep(input logic [IDX_W-1:0] idx);
    return {6{idx}};
  endfunction

  task automatic cfg(input logic [NID_W-1:0] nid, input bit twe, input logic [63:0] tt,
                     input bit mwe, input logic [6*IDX_W-1:0] mp);
    @(negedge clk);
    cfg_neuron   = nid;
    cfg_tt_we    = twe;
    cfg_tt_data  = tt;
    cfg_map_we   = mwe;
    cfg_map_data = mp;
    @(negedge clk);
    cfg_tt_we  = 1'b0;
    cfg_map_we = 1'b0;
  endtask

  // Accept one vector, check exact latency, optional DONE backpressure and
  // an optional config write to neuron 4 mid-evaluation.
  task automatic run(input logic [IN_WIDTH-1:0] vec, input logic [15:0] exp,
                     input string tag, input int hold, input bit lock);
    @(negedge clk);
    check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    in_valid = 1'b1;
    in_data  = vec;
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, "_busy"}, 128'(busy), 128'd1);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (lock && i == 3) begin
        cfg_neuron  = 5'd4;
        cfg_tt_data = '1;
        cfg_tt_we   = 1'b1;
        #1 check({tag, "_cfg_ready_eval"}, 128'(cfg_ready), 128'd0);
      end
      if (lock && i == 4) cfg_tt_we = 1'b0;
      if (i == 15) check({tag, "_valid_early"}, 128'(out_valid), 128'd0);
      if (i == 16) check({tag, "_valid_lat"}, 128'(out_valid), 128'd1);
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, "_hold"}, {out_valid, in_ready, out_data}, {1'b1, 1'b0, exp});
    end
    check({tag, "_data"}, 128'(out_data), 128'(exp));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_release"}, {out_valid, busy, in_ready}, {1'b0, 1'b0, 1'b1});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_state", {out_valid, busy, cfg_ready, out_data}, {3'b001, 16'h0000});
    rst = 1'b0;

    run('1, 16'h0000, "zero_tables", 0, 1'b0);

    // Identity neuron 0 on input bit 5.
    cfg(5'd0, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, {35'd0, 7'd5});
    run(100'h20, 16'h0001, "ident_one", 0, 1'b0);
    run(100'h1F, 16'h0000, "ident_zero", 0, 1'b0);

    // Full layer of 6-input ANDs, neuron n reads bit n.
    for (int n = 0; n < NUM_NEURONS; n++)
      cfg(NID_W'(n), 1'b1, 64'h8000_0000_0000_0000, 1'b1, rep(IDX_W'(n)));
    run(100'hA5, 16'h00A5, "and_a5", 0, 1'b0);
    run(100'hF00F, 16'hF00F, "and_f00f", 0, 1'b0);
    run(100'h5A5A, 16'h5A5A, "backpressure", 10, 1'b0);

    // Config wins over input in the same IDLE cycle.
    @(negedge clk);
    cfg_neuron  = 5'd1;
    cfg_tt_data = '1;
    cfg_tt_we   = 1'b1;
    in_valid    = 1'b1;
    in_data     = 100'hA5;
    #1 check("prio_in_ready", 128'(in_ready), 128'd0);
    @(negedge clk);
    cfg_tt_we = 1'b0;
    in_valid  = 1'b0;
    check("prio_not_accepted", 128'(busy), 128'd0);
    run(100'hA5, 16'h00A7, "prio_written", 0, 1'b0);

    run(100'hA5, 16'h00A7, "lock_during", 0, 1'b1);
    run(100'hA5, 16'h00A7, "lock_after", 0, 1'b0);

    // Neuron 2 fires only on LUT address 0; index 127 is past IN_WIDTH.
    cfg(5'd2, 1'b1, 64'h1, 1'b1, rep(7'd127));
    run('1, 16'hFFFF, "oor_ones", 0, 1'b0);
    run('0, 16'h0006, "oor_zeros", 0, 1'b0);
    cfg(5'd20, 1'b1, '1, 1'b1, '0);
    run('0, 16'h0006, "oor_neuron", 0, 1'b0);

    // Reset mid-evaluation.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = '1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1 check("mid_reset", {out_valid, busy, cfg_ready, out_data}, {3'b001, 16'h0000});
    @(negedge clk);
    rst = 1'b0;
    run('1, 16'h0000, "after_reset", 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lut_layer_sequencer.md
Name: lut_layer_sequencer

Overview:
Time-multiplexed evaluator for a layer of 6-input, 1-output LUT neurons whose truth tables and fan-in wiring are programmed at runtime rather than synthesised as fixed case ROMs. It captures one input activation vector, evaluates one neuron per cycle against a shared truth-table and fan-in map store, and presents the packed output vector through a valid/ready handshake. It sits between layer stages in place of a bank of hard-coded neuron modules, for fast model swaps without re-synthesis.

Parameters:
IN_WIDTH, 128, width of input activation vector (bits)
NUM_NEURONS, 16, neurons in the layer; also output vector width
IDX_W, 7, width of a fan-in index; must satisfy 2**IDX_W >= IN_WIDTH
NID_W, 4, neuron index width; must satisfy 2**NID_W >= NUM_NEURONS

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_ready  out  1  configuration writes accepted this cycle (high only in IDLE)
cfg_tt_we  in  1  write truth table of neuron cfg_neuron
cfg_map_we  in  1  write fan-in map of neuron cfg_neuron
cfg_neuron  in  NID_W  target neuron index
cfg_tt_data  in  64  truth table; bit a is the output for LUT address a
cfg_map_data  in  6*IDX_W  fan-in indices; field k at [k*IDX_W +: IDX_W] drives LUT address bit k
in_valid  in  1  input vector valid
in_ready  out  1  block can accept an input vector
in_data  in  IN_WIDTH  input activation vector
out_valid  out  1  output vector valid
out_ready  in  1  downstream accepts output
out_data  out  NUM_NEURONS  packed neuron outputs; bit n is neuron n
busy  out  1  state is not IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; out_valid=0; out_data=0; busy=0; neuron counter=0; captured input register=0; all truth tables=0; all fan-in maps=0. Reset mid-EVAL or mid-DONE aborts the evaluation and discards any pending output.
- FSM: IDLE -> EVAL on in_valid&&in_ready; EVAL -> DONE after neuron NUM_NEURONS-1 is evaluated; DONE -> IDLE on out_ready.
- IDLE: cfg_ready=1. in_ready = ~(cfg_tt_we|cfg_map_we): configuration has priority, and an input is not accepted in a cycle with a config write.
- Config writes:
  - Take effect at the clock edge and are visible to the next evaluation.
  - tt and map writes to the same neuron in one cycle both commit.
  - cfg_neuron >= NUM_NEURONS: write dropped, no other effect.
  - Writes when cfg_ready=0 are dropped silently.
- Capture: on in_valid&&in_ready, register in_data, clear counter n=0, clear out_data.
- EVAL: one neuron per cycle.
  - addr[k] = in_reg[map[n][k]], k=0..5; addr[0] is the LSB.
  - out_data[n] <= tt[n][addr] at the edge; then n increments.
  - A map index >= IN_WIDTH reads as 0.
- Latency: input accepted at edge t -> out_valid=1 after edge t+NUM_NEURONS (16 cycles at default). out_valid is registered.
- DONE: out_valid=1; out_data stable. On out_ready, out_valid drops at the next edge and the FSM returns to IDLE. The earliest next input accept is the cycle after return, so no overlap (throughput 1 vector per NUM_NEURONS+2 cycles minimum).
- out_data holds its last value in IDLE until the next capture. out_valid=0 outside DONE.
- in_ready=0 and cfg_ready=0 throughout EVAL and DONE; in_valid and config strobes are ignored there.

Test Plan:
- Reset state: assert rst mid-run -> out_valid=0, out_data=0, busy=0, cfg_ready=1. Any evaluation after reset yields out_data=16'h0000 because all tables are zero.
- Identity neuron: neuron 0 tt=64'hAAAA_AAAA_AAAA_AAAA, map field0=5. Input bit5=1 -> out_data[0]=1. Input bit5=0 -> out_data[0]=0. out_valid rises exactly 16 cycles after accept.
- Full layer: neuron n tt=64'h8000_0000_0000_0000 (6-input AND), all six map fields = n. Input 128'h0000_...._00A5 -> out_data=16'h00A5.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid and out_data stable, in_ready=0. Release -> out_valid=0 next edge, in_ready=1 the following cycle.
- Config priority and lockout: assert cfg_tt_we and in_valid together in IDLE -> table written, input not accepted. Write with cfg_neuron=4 during EVAL -> neuron 4 unchanged on the next evaluation.
- Out-of-range: map index 127 with IN_WIDTH=100 -> addr bit reads 0. cfg_neuron=20 write -> no neuron changes.
